// File: rtl/buffered_fifo_pkg.sv
// Pointer helpers shared by the read and write sides of the buffered FIFO.
// Pointers are binary with one extra MSB that toggles on every address wrap.
package buffered_fifo_pkg;

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Address field wraps to 0 after depth-1 and the bit just above it toggles.
    function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input int depth);
        logic [31:0] addr_mask;
        logic [31:0] wrap_bit;
        logic [31:0] nxt;
        addr_mask = 32'(depth - 1);
        wrap_bit  = 32'(depth);
        if ((ptr & addr_mask) == addr_mask) begin
            nxt = (ptr & ~addr_mask) ^ wrap_bit;
        end else begin
            nxt = ptr + 32'd1;
        end
        return nxt & (wrap_bit | addr_mask);
    endfunction

endpackage

// File: rtl/mem_reader_cache.sv
// Small count-based register FIFO that lands RAM read returns.
// The head entry is read combinationally; push and pop may coincide at any fill level.
module mem_reader_cache
    import buffered_fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = 11,
    parameter int CACHE_DEPTH = 8,
    parameter int CNT_W       = $clog2(CACHE_DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_o,
    output logic [CNT_W-1:0]      count_o,
    output logic                  empty_o,
    output logic                  full_o
);

    localparam int IDX_W = (CACHE_DEPTH > 1) ? $clog2(CACHE_DEPTH) : 1;

    logic [DATA_WIDTH-1:0] entry_q [CACHE_DEPTH];
    logic [IDX_W-1:0]      wr_idx_q;
    logic [IDX_W-1:0]      rd_idx_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  do_push;
    logic                  do_pop;

    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
        if (32'(idx) == CACHE_DEPTH - 1) begin
            return '0;
        end
        return idx + IDX_W'(1);
    endfunction

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CNT_W'(CACHE_DEPTH));
    assign count_o = cnt_q;
    assign head_o  = entry_q[rd_idx_q];

    // A pop frees its slot in the same cycle, so a push into a full cache is accepted only alongside a pop.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < CACHE_DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                entry_q[wr_idx_q] <= push_data_i;
                wr_idx_q          <= idx_inc(wr_idx_q);
            end
            if (do_pop) begin
                rd_idx_q <= idx_inc(rd_idx_q);
            end
            cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/fifo_mem_reader.sv
// Read side of the buffered FIFO: fetches words from a fixed-latency RAM under a credit
// limit, lands them in a register cache and presents the head word on an Avalon-ST source.
module fifo_mem_reader
    import buffered_fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = 11,
    parameter int MEM_DEPTH   = 16,
    parameter int LATENCY     = 4,
    parameter int CACHE_DEPTH = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [ptr_w(MEM_DEPTH)-1:0]   wr_ptr_i,
    output logic [ptr_w(MEM_DEPTH)-1:0]   rd_ptr_o,
    output logic [ptr_w(MEM_DEPTH)-1:0]   occupancy_o,
    output logic                          mem_rd_en_o,
    output logic [$clog2(MEM_DEPTH)-1:0]  mem_rd_addr_o,
    input  logic [DATA_WIDTH-1:0]         mem_rd_data_i,
    output logic [DATA_WIDTH-1:0]         data_o,
    output logic                          valid_o,
    input  logic                          ready_i
);

    localparam int ADDR_W = $clog2(MEM_DEPTH);
    localparam int PTR_W  = ptr_w(MEM_DEPTH);
    localparam int CNT_W  = $clog2(CACHE_DEPTH + 1);
    localparam int INF_W  = $clog2(LATENCY + 1);

    logic [PTR_W-1:0]      rd_ptr_q;
    logic [LATENCY-1:0]    vld_q;
    logic [LATENCY-1:0]    vld_d;
    logic [INF_W-1:0]      inflight;
    logic [CNT_W-1:0]      cache_cnt;
    logic [DATA_WIDTH-1:0] cache_head;
    logic                  cache_empty;
    logic                  cache_full;
    logic                  mem_empty;
    logic                  credit_ok;
    logic                  issue;
    logic                  push;
    logic                  pop;

    // Source handshake: a word transfers in every cycle where valid_o and ready_i are both 1;
    // once valid_o rises it stays high with data_o unchanged until that transfer happens, and
    // ready_i has no effect while valid_o is low.
    assign valid_o = rst_n_i && !cache_empty;
    assign data_o  = rst_n_i ? cache_head : '0;
    assign pop     = valid_o && ready_i;

    assign rd_ptr_o      = rst_n_i ? rd_ptr_q : '0;
    assign mem_rd_addr_o = rd_ptr_o[ADDR_W-1:0];
    assign occupancy_o   = wr_ptr_i - rd_ptr_o;
    assign mem_empty     = (wr_ptr_i == rd_ptr_o);

    // Every issued read owns a cache slot until it is popped; a pop this cycle frees one slot early.
    assign credit_ok   = (32'(inflight) + 32'(cache_cnt)) < CACHE_DEPTH;
    assign issue       = rst_n_i && !mem_empty && (credit_ok || pop);
    assign mem_rd_en_o = issue;

    assign push = vld_q[LATENCY-1];

    always_comb begin
        vld_d    = '0;
        inflight = '0;
        vld_d[0] = issue;
        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
        end
        for (int i = 0; i < LATENCY; i++) begin
            inflight = inflight + INF_W'(vld_q[i]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rd_ptr_q <= '0;
            vld_q    <= '0;
        end else begin
            if (issue) begin
                rd_ptr_q <= PTR_W'(ptr_inc(32'(rd_ptr_q), MEM_DEPTH));
            end
            vld_q <= vld_d;
        end
    end

    mem_reader_cache #(
        .DATA_WIDTH  (DATA_WIDTH),
        .CACHE_DEPTH (CACHE_DEPTH),
        .CNT_W       (CNT_W)
    ) u_cache (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .push_i      (push),
        .push_data_i (mem_rd_data_i),
        .pop_i       (pop),
        .head_o      (cache_head),
        .count_o     (cache_cnt),
        .empty_o     (cache_empty),
        .full_o      (cache_full)
    );

    a_no_push_when_full : assert property (
        @(posedge clk_i) disable iff (!rst_n_i) !(push && cache_full)
    );

    a_occupancy_in_range : assert property (
        @(posedge clk_i) disable iff (!rst_n_i) 32'(occupancy_o) <= MEM_DEPTH
    );

endmodule

// File: tb/tb_fifo_mem_reader.sv
// Bench for fifo_mem_reader: a fixed-latency RAM model, a writer driving wr_ptr_i, and a
// scoreboard that checks every word taken from the Avalon-ST source in order.
module tb_fifo_mem_reader;

    localparam int DW  = 11;
    localparam int MD  = 16;
    localparam int LAT = 4;
    localparam int CD  = 8;
    localparam int AW  = 4;
    localparam int PW  = 5;

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic [PW-1:0] wr_ptr_i;
    logic [PW-1:0] rd_ptr_o;
    logic [PW-1:0] occupancy_o;
    logic          mem_rd_en_o;
    logic [AW-1:0] mem_rd_addr_o;
    logic [DW-1:0] mem_rd_data_i;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic          ready_i;

    // ---------------- clock ----------------
    always #5 clk_i = ~clk_i;

    fifo_mem_reader #(
        .DATA_WIDTH  (DW),
        .MEM_DEPTH   (MD),
        .LATENCY     (LAT),
        .CACHE_DEPTH (CD)
    ) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .wr_ptr_i      (wr_ptr_i),
        .rd_ptr_o      (rd_ptr_o),
        .occupancy_o   (occupancy_o),
        .mem_rd_en_o   (mem_rd_en_o),
        .mem_rd_addr_o (mem_rd_addr_o),
        .mem_rd_data_i (mem_rd_data_i),
        .data_o        (data_o),
        .valid_o       (valid_o),
        .ready_i       (ready_i)
    );

    // ---------------- RAM model: address sampled at the edge, data LAT cycles later ----------------
    logic [DW-1:0] ram [MD];
    logic [DW-1:0] ram_pipe [LAT];

    always @(posedge clk_i) begin
        ram_pipe[0] <= ram[mem_rd_addr_o];
        for (int i = 1; i < LAT; i++) begin
            ram_pipe[i] <= ram_pipe[i-1];
        end
    end
    assign mem_rd_data_i = ram_pipe[LAT-1];

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] sb_exp;
    int n_cmp   = 0;
    int n_fail  = 0;
    int rx_cnt  = 0;
    int issue_cnt = 0;

    always @(negedge clk_i) begin
        if (rst_n_i === 1'b1) begin
            if (mem_rd_en_o === 1'b1) issue_cnt++;
            if (valid_o === 1'b1 && ready_i === 1'b1) begin
                rx_cnt++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_underflow: data_o=%h delivered, expected no word", data_o);
                end else begin
                    sb_exp = exp_q.pop_front();
                    if (data_o !== sb_exp) begin
                        n_fail++;
                        $display("FAIL sb_data: data_o=%h, expected %h", data_o, sb_exp);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks and background writer/consumer ----------------
    int wr_left    = 0;
    bit wr_random  = 1'b0;
    int burst_left = 0;
    int gap_left   = 0;
    bit rnd_ready  = 1'b0;
    bit wr_go;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic write_word(input logic [DW-1:0] d);
        ram[wr_ptr_i[AW-1:0]] = d;
        exp_q.push_back(d);
        wr_ptr_i = wr_ptr_i + PW'(1);
    endtask

    always @(posedge clk_i) begin
        #1;
        if (rst_n_i === 1'b1 && wr_left > 0) begin
            wr_go = 1'b0;
            if (!wr_random) begin
                wr_go = 1'b1;
            end else if (burst_left > 0) begin
                wr_go = 1'b1;
            end else if (gap_left > 0) begin
                gap_left--;
            end else begin
                burst_left = $urandom_range(10, 1);
                gap_left   = $urandom_range(6, 0);
            end
            if (wr_go && 32'(occupancy_o) < MD) begin
                write_word(DW'($urandom_range(2047, 0)));
                wr_left--;
                if (burst_left > 0) burst_left--;
            end
        end
    end

    always @(posedge clk_i) begin
        #1;
        if (rnd_ready) ready_i = ($urandom_range(1, 0) == 1);
    end

    task automatic wait_rx(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk_i);
            if (rx_cnt >= target && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        tick();
        rst_n_i  = 1'b0;
        wr_ptr_i = PW'(5);
        ready_i  = 1'b0;
        exp_q.delete();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            n_cmp++;
            if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: valid_o=%b, expected 0", valid_o); end
            n_cmp++;
            if (mem_rd_en_o !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: mem_rd_en_o=%b, expected 0", mem_rd_en_o); end
            n_cmp++;
            if (rd_ptr_o !== PW'(0)) begin n_fail++; $display("FAIL reset_rd_ptr: rd_ptr_o=%h, expected 0", rd_ptr_o); end
            n_cmp++;
            if (data_o !== DW'(0)) begin n_fail++; $display("FAIL reset_data: data_o=%h, expected 0", data_o); end
            tick();
        end
        rst_n_i = 1'b1;
        @(negedge clk_i);
        n_cmp++;
        if (mem_rd_en_o !== 1'b1 || mem_rd_addr_o !== AW'(0)) begin
            n_fail++;
            $display("FAIL release_first_read: rd_en=%b addr=%h, expected 1 addr 0", mem_rd_en_o, mem_rd_addr_o);
        end
        tick();
        rst_n_i  = 1'b0;
        wr_ptr_i = '0;
        exp_q.delete();
        tick();
        tick();
        rst_n_i = 1'b1;
    endtask

    task automatic test_single();
        ready_i = 1'b1;
        write_word(DW'(11'h2AA));
        @(negedge clk_i);
        n_cmp++;
        if (mem_rd_en_o !== 1'b1 || mem_rd_addr_o !== AW'(0)) begin
            n_fail++;
            $display("FAIL single_issue: rd_en=%b addr=%h, expected 1 addr 0", mem_rd_en_o, mem_rd_addr_o);
        end
        tick();
        @(negedge clk_i);
        n_cmp++;
        if (rd_ptr_o !== PW'(1) || mem_rd_en_o !== 1'b0) begin
            n_fail++;
            $display("FAIL single_rd_ptr: rd_ptr_o=%h rd_en=%b, expected 01 and 0", rd_ptr_o, mem_rd_en_o);
        end
        for (int c = 2; c <= 4; c++) begin
            tick();
            @(negedge clk_i);
            n_cmp++;
            if (valid_o !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: c+%0d valid_o=%b, expected 0", c, valid_o); end
        end
        tick();
        @(negedge clk_i);
        n_cmp++;
        if (valid_o !== 1'b1 || data_o !== DW'(11'h2AA)) begin
            n_fail++;
            $display("FAIL single_latency: c+5 valid_o=%b data_o=%h, expected 1 and 2aa", valid_o, data_o);
        end
        tick();
    endtask

    task automatic test_stream();
        int base_rx;
        int gaps;
        bit started;
        bit wrap_seen;
        bit ok;
        logic [PW-1:0] prev_ptr;
        base_rx   = rx_cnt;
        gaps      = 0;
        started   = 1'b0;
        wrap_seen = 1'b0;
        ok        = 1'b0;
        ready_i   = 1'b1;
        wr_random = 1'b0;
        wr_left   = 32;
        prev_ptr  = rd_ptr_o;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk_i);
            if (prev_ptr == PW'(5'h0F) && rd_ptr_o != prev_ptr) begin
                wrap_seen = 1'b1;
                n_cmp++;
                if (rd_ptr_o !== PW'(5'h10)) begin n_fail++; $display("FAIL stream_wrap: rd_ptr_o=%h after 0f, expected 10", rd_ptr_o); end
            end
            prev_ptr = rd_ptr_o;
            if (valid_o === 1'b1) started = 1'b1;
            else if (started && rx_cnt - base_rx < 32) gaps++;
            if (rx_cnt - base_rx >= 32 && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL stream_timeout: %0d words received, expected 32", rx_cnt - base_rx); end
        n_cmp++;
        if (gaps != 0) begin n_fail++; $display("FAIL stream_gaps: %0d idle cycles, expected 0", gaps); end
        n_cmp++;
        if (!wrap_seen) begin n_fail++; $display("FAIL stream_wrap_seen: rd_ptr_o never left 0f, expected 0f->10"); end
        tick();
    endtask

    task automatic test_backpressure();
        int base_rx;
        int base_issue;
        logic [PW-1:0] base_ptr;
        logic [DW-1:0] held_data;
        bit held;
        int unstable;
        int dropped;
        bit ok;
        tick();
        ready_i    = 1'b0;
        base_rx    = rx_cnt;
        base_issue = issue_cnt;
        base_ptr   = rd_ptr_o;
        held       = 1'b0;
        held_data  = '0;
        unstable   = 0;
        dropped    = 0;
        wr_random  = 1'b0;
        wr_left    = 16;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_i);
            if (valid_o === 1'b1) begin
                if (!held) begin
                    held      = 1'b1;
                    held_data = data_o;
                end else if (data_o !== held_data) begin
                    unstable++;
                end
            end else if (held) begin
                dropped++;
            end
        end
        n_cmp++;
        if (issue_cnt - base_issue != 8) begin n_fail++; $display("FAIL bp_issue_count: %0d reads issued, expected 8", issue_cnt - base_issue); end
        n_cmp++;
        if (PW'(rd_ptr_o - base_ptr) !== PW'(8)) begin n_fail++; $display("FAIL bp_rd_ptr: advanced by %0d, expected 8", PW'(rd_ptr_o - base_ptr)); end
        n_cmp++;
        if (occupancy_o !== PW'(8)) begin n_fail++; $display("FAIL bp_occupancy: occupancy_o=%0d, expected 8", occupancy_o); end
        n_cmp++;
        if (!held || unstable != 0 || dropped != 0) begin
            n_fail++;
            $display("FAIL bp_hold: held=%b unstable=%0d dropped=%0d, expected 1 0 0", held, unstable, dropped);
        end
        tick();
        ready_i = 1'b1;
        wait_rx(base_rx + 16, 300, ok);
        n_cmp++;
        if (!ok || rx_cnt - base_rx != 16) begin n_fail++; $display("FAIL bp_drain: %0d words received, expected 16", rx_cnt - base_rx); end
        tick();
    endtask

    task automatic test_reset_midflight();
        int base_rx;
        bit ok;
        ready_i = 1'b0;
        write_word(DW'(11'h401));
        write_word(DW'(11'h402));
        repeat (4) tick();
        write_word(DW'(11'h403));
        write_word(DW'(11'h404));
        write_word(DW'(11'h405));
        repeat (2) tick();
        @(negedge clk_i);
        n_cmp++;
        if (valid_o !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: valid_o=%b with words cached, expected 1", valid_o); end
        tick();
        rst_n_i  = 1'b0;
        wr_ptr_i = '0;
        exp_q.delete();
        tick();
        tick();
        rst_n_i = 1'b1;
        ready_i = 1'b1;
        base_rx = rx_cnt;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_i);
            n_cmp++;
            if (valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_stale: valid_o=%b data_o=%h after reset, expected 0", valid_o, data_o); end
        end
        tick();
        write_word(DW'(11'h011));
        write_word(DW'(11'h022));
        write_word(DW'(11'h033));
        wait_rx(base_rx + 3, 100, ok);
        n_cmp++;
        if (!ok || rx_cnt - base_rx != 3) begin n_fail++; $display("FAIL mid_new_words: %0d words received, expected 3", rx_cnt - base_rx); end
        tick();
    endtask

    task automatic test_random();
        int base_rx;
        bit ok;
        base_rx    = rx_cnt;
        burst_left = 0;
        gap_left   = 0;
        wr_random  = 1'b1;
        rnd_ready  = 1'b1;
        wr_left    = 1000;
        wait_rx(base_rx + 1000, 30000, ok);
        n_cmp++;
        if (!ok || rx_cnt - base_rx != 1000) begin n_fail++; $display("FAIL random_count: %0d words received, expected 1000", rx_cnt - base_rx); end
        tick();
        rnd_ready = 1'b0;
        wr_random = 1'b0;
        wr_left   = 0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst_n_i  = 1'b0;
        wr_ptr_i = '0;
        ready_i  = 1'b0;
        for (int i = 0; i < MD; i++) ram[i] = '0;
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
